// File: rtl/branch_forward_ctrl.sv
// Branch operand forwarding / stall control for a branch resolved in ID.
// Tracks shadow copies of EX, MEM and WB (valid, write-enable, dest, load)
// and, for each branch source register, picks the youngest matching producer
// or requests a stall while a load result has not yet reached WB.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   id_valid            ID holds a real instruction
//   id_is_branch        ID instruction is a branch resolved in ID
//   id_rs1, id_rs2      branch source registers
//   id_uses_rs2         operand 2 is architecturally read
//   id_reg_write        ID instruction writes a register
//   id_dest             ID destination register
//   id_is_load          ID instruction is a load
//   flush               kill the ID instruction (bubble into EX)
//   forward_c           [1:0] rd1 source, [3:2] rd2 source
//                       00 regfile, 01 EX ALU, 10 EX/MEM ALU, 11 write-back
//   stall               hold PC and IF/ID, bubble into EX (combinational)
//   stall_cycles        saturating count of stalled cycles
module branch_forward_ctrl #(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_is_load,
    input  logic              flush,
    output logic [3:0]        forward_c,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] dest;
        logic              load;
    } stage_t;

    // Resolution result: bit 2 = need_stall, bits [1:0] = forward code.
    localparam logic [2:0] RES_RF    = 3'b000;
    localparam logic [2:0] RES_EX    = 3'b001;
    localparam logic [2:0] RES_MEM   = 3'b010;
    localparam logic [2:0] RES_WB    = 3'b011;
    localparam logic [2:0] RES_STALL = 3'b100;

    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;

    logic [2:0] res1;
    logic [2:0] res2;
    logic       branch_active;

    // Youngest-first producer lookup; a load still in EX or MEM cannot forward.
    function automatic logic [2:0] resolve(
        input logic [REG_AW-1:0] rs,
        input stage_t            ex,
        input stage_t            mem,
        input stage_t            wb
    );
        logic [2:0] r;
        r = RES_RF;
        if (ex.valid && ex.wr && (ex.dest == rs)) begin
            r = ex.load ? RES_STALL : RES_EX;
        end else if (mem.valid && mem.wr && (mem.dest == rs)) begin
            r = mem.load ? RES_STALL : RES_MEM;
        end else if (wb.valid && wb.wr && (wb.dest == rs)) begin
            r = RES_WB;
        end
        return r;
    endfunction

    // Forward select and stall request for the branch currently in ID.
    always_comb begin
        branch_active = id_valid & id_is_branch;
        res1          = resolve(id_rs1, ex_q, mem_q, wb_q);
        res2          = RES_RF;
        if (id_uses_rs2) begin
            res2 = resolve(id_rs2, ex_q, mem_q, wb_q);
        end
        forward_c = 4'b0000;
        stall     = 1'b0;
        if (branch_active) begin
            forward_c = {res2[1:0], res1[1:0]};
            stall     = res1[2] | res2[2];
        end
    end

    // Shadow pipeline advance; stall or flush inserts a bubble into EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (!stall && !flush) begin
                ex_q <= '{valid: id_valid, wr: id_reg_write, dest: id_dest, load: id_is_load};
            end else begin
                ex_q <= '0;
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_forward_ctrl.sv
// Directed table-driven bench for branch_forward_ctrl. Each table row is one
// clock cycle of ID inputs with hand-computed expected outputs. A second
// instance with a 3-bit counter shares the inputs to exercise saturation.
module tb_branch_forward_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_is_branch;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic       id_uses_rs2;
    logic       id_reg_write;
    logic [3:0] id_dest;
    logic       id_is_load;
    logic       flush;
    logic [3:0] forward_c;
    logic       stall;
    logic [15:0] stall_cycles;
    logic [3:0] forward_c_s;
    logic       stall_s;
    logic [2:0] stall_cycles_s;

    int n_tests;
    int n_fail;

    branch_forward_ctrl #(.REG_AW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_dest(id_dest), .id_is_load(id_is_load),
        .flush(flush), .forward_c(forward_c), .stall(stall), .stall_cycles(stall_cycles)
    );

    branch_forward_ctrl #(.REG_AW(4), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_dest(id_dest), .id_is_load(id_is_load),
        .flush(flush), .forward_c(forward_c_s), .stall(stall_s), .stall_cycles(stall_cycles_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic       br;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u2;
        logic       wr;
        logic [3:0] dest;
        logic       ld;
        logic       fl;
        logic [3:0] fc;
        logic       st;
        logic       chk_fc;
        int         cnt;
    } vec_t;

    localparam int NV = 38;
    vec_t tbl [NV];

    function automatic vec_t mk(input int r, input int v, input int br, input int rs1,
                                input int rs2, input int u2, input int wr, input int dest,
                                input int ld, input int fl, input int fc, input int st,
                                input int cnt);
        vec_t x;
        x.rst    = 1'(r);
        x.v      = 1'(v);
        x.br     = 1'(br);
        x.rs1    = 4'(rs1);
        x.rs2    = 4'(rs2);
        x.u2     = 1'(u2);
        x.wr     = 1'(wr);
        x.dest   = 4'(dest);
        x.ld     = 1'(ld);
        x.fl     = 1'(fl);
        x.fc     = 4'(fc);
        x.st     = 1'(st);
        x.chk_fc = (st == 0);
        x.cnt    = cnt;
        return x;
    endfunction

    task automatic apply(input vec_t x);
        rst          = x.rst;
        id_valid     = x.v;
        id_is_branch = x.br;
        id_rs1       = x.rs1;
        id_rs2       = x.rs2;
        id_uses_rs2  = x.u2;
        id_reg_write = x.wr;
        id_dest      = x.dest;
        id_is_load   = x.ld;
        flush        = x.fl;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        apply(mk(1, 1, 1, 3, 3, 1, 1, 3, 1, 0, 0, 0, 0));

        // rst, v, br, rs1, rs2, u2, wr, dest, ld, fl, fc, st, cnt
        tbl[0]  = mk(1, 1, 1, 3, 3, 1, 1, 3, 1, 0, 0, 0, 0);     // reset, arbitrary inputs
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);     // empty pipe
        tbl[2]  = mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);     // ADD r3
        tbl[3]  = mk(0, 1, 1, 3, 5, 1, 0, 0, 0, 0, 4'b0001, 0, 0); // BEQ r3,r5: EX
        tbl[4]  = mk(0, 1, 1, 3, 5, 1, 0, 0, 0, 0, 4'b0010, 0, 0); // MEM
        tbl[5]  = mk(0, 1, 1, 3, 5, 1, 0, 0, 0, 0, 4'b0011, 0, 0); // WB
        tbl[6]  = mk(0, 1, 1, 3, 5, 1, 0, 0, 0, 0, 4'b0000, 0, 0); // gone
        tbl[7]  = mk(0, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0);     // LD r4
        tbl[8]  = mk(0, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0);     // BNE r1,r4 stall
        tbl[9]  = mk(0, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 1);     // stall 2
        tbl[10] = mk(0, 1, 1, 1, 4, 1, 0, 0, 0, 0, 4'b1100, 0, 2);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 2);     // ADD r2
        tbl[12] = mk(0, 1, 0, 2, 2, 1, 1, 2, 0, 0, 0, 0, 2);     // SUB r2 (non-branch, EX hit)
        tbl[13] = mk(0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 4'b0001, 0, 2); // youngest wins
        tbl[14] = mk(0, 1, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 2);     // flushed write r6
        tbl[15] = mk(0, 1, 1, 6, 6, 1, 0, 0, 0, 0, 0, 0, 2);
        tbl[16] = mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 2);     // ADD r9
        tbl[17] = mk(0, 1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 2);     // rs2 unused
        tbl[18] = mk(0, 1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 2);    // LD r10
        tbl[19] = mk(0, 1, 1, 10, 0, 0, 0, 0, 0, 1, 0, 1, 2);    // stall + flush
        tbl[20] = mk(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        tbl[21] = mk(0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 4);
        tbl[22] = mk(0, 1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0, 4);    // LD r11
        tbl[23] = mk(0, 1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 4);    // LD r12
        tbl[24] = mk(0, 1, 1, 11, 12, 1, 0, 0, 0, 0, 0, 1, 4);   // two loads
        tbl[25] = mk(0, 1, 1, 11, 12, 1, 0, 0, 0, 0, 0, 1, 5);
        tbl[26] = mk(0, 1, 1, 11, 12, 1, 0, 0, 0, 0, 4'b1100, 0, 6);
        tbl[27] = mk(0, 1, 0, 0, 0, 0, 1, 13, 1, 0, 0, 0, 6);    // LD r13
        tbl[28] = mk(0, 1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 6);    // ADD r13
        tbl[29] = mk(0, 1, 1, 13, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 6); // ALU in EX hides load
        tbl[30] = mk(0, 1, 0, 0, 0, 0, 1, 14, 1, 0, 0, 0, 6);    // LD r14
        tbl[31] = mk(0, 0, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 6);    // invalid ID
        tbl[32] = mk(0, 1, 1, 14, 0, 0, 0, 0, 0, 0, 0, 1, 6);    // load in MEM
        tbl[33] = mk(0, 1, 1, 14, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 7);
        tbl[34] = mk(0, 1, 0, 0, 0, 0, 1, 15, 1, 0, 0, 0, 7);    // LD r15
        tbl[35] = mk(0, 1, 1, 15, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        tbl[36] = mk(0, 1, 1, 15, 0, 0, 0, 0, 0, 0, 0, 1, 8);
        tbl[37] = mk(0, 1, 1, 15, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 9);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            apply(tbl[i]);
            @(negedge clk);
            if (tbl[i].chk_fc) check("forward_c", i, 32'(forward_c), 32'(tbl[i].fc));
            check("stall", i, 32'(stall), 32'(tbl[i].st));
            check("stall_cycles", i, 32'(stall_cycles), 32'(tbl[i].cnt));
            check("stall_cycles_sat", i, 32'(stall_cycles_s),
                  32'((tbl[i].cnt > 7) ? 7 : tbl[i].cnt));
        end

        // Reset asserted during the first cycle of a load-use stall.
        @(posedge clk);
        #1;
        apply(mk(0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0));        // LD r7
        @(posedge clk);
        #1;
        apply(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));        // branch on r7
        #1;
        check("rst_pre_stall", 100, 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_stall", 101, 32'(stall), 32'd0);
        check("rst_fc", 101, 32'(forward_c), 32'd0);
        check("rst_cnt", 101, 32'(stall_cycles), 32'd0);
        check("rst_cnt_sat", 101, 32'(stall_cycles_s), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 102, 32'(stall), 32'd0);
        check("post_rst_fc", 102, 32'(forward_c), 32'd0);
        check("post_rst_cnt", 102, 32'(stall_cycles), 32'd0);
        @(negedge clk);
        check("post_rst_stall2", 103, 32'(stall), 32'd0);
        check("post_rst_cnt2", 103, 32'(stall_cycles), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_forward_ctrl.md
Name: branch_forward_ctrl

Overview:
- Produces the 4-bit forward_c select code and the branch stall request consumed by the ID-stage branch operand muxes.
- Keeps its own shadow of the destination register, write-enable and load flag for the EX, MEM and WB pipeline stages.
- Compares those stages against the source registers of a branch sitting in ID.
- Selects the youngest valid producer for each operand, or stalls ID while a load result is not yet available.

Parameters:
- REG_AW, 4, register address width (16 architectural registers).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- id_valid  input  1  the ID stage holds a real instruction.
- id_is_branch  input  1  the ID instruction is a branch that resolves in ID.
- id_rs1  input  REG_AW  branch source operand 1.
- id_rs2  input  REG_AW  branch source operand 2.
- id_uses_rs2  input  1  operand 2 is architecturally read.
- id_reg_write  input  1  the ID instruction writes a register.
- id_dest  input  REG_AW  destination register of the ID instruction.
- id_is_load  input  1  the ID instruction is a load (result available after MEM).
- flush  input  1  kill the ID instruction: a bubble enters EX.
- forward_c  output  4  [1:0] selects the rd1 source, [3:2] selects the rd2 source.
- stall  output  1  hold PC and IF/ID, insert a bubble into EX.
- stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Shadow stages EX, MEM and WB each hold valid, wr, dest and load. They are the only state apart from stall_cycles.
- Reset (asynchronous, immediate): all shadow valid bits = 0 and stall_cycles = 0. Outputs therefore read forward_c = 4'b0000 and stall = 0 during and after reset.
- Reset asserted mid-operation discards all in-flight entries. There is no pending stall after reset release.

Clocked shadow advance (every clk edge, rst low):
- WB <= MEM and MEM <= EX, unconditionally.
- EX <= {id_valid, id_reg_write, id_dest, id_is_load} when stall=0 and flush=0.
- Otherwise EX.valid <= 0 (bubble).
- flush and stall both high: bubble, and flush wins; stall is still reported for that cycle.

forward_c / stall are combinational in the same cycle from the shadows and ID inputs. Per operand rsN:
- A stage "hits" when valid & wr & dest == rsN.
- EX hit: load=1 gives need_stall; else code 2'b01 (current ALU output).
- Otherwise, MEM hit: load=1 gives need_stall; else code 2'b10 (EX/MEM ALU result).
- Otherwise, WB hit: code 2'b11 (write-back data, loads included).
- Otherwise: code 2'b00 (register file).
- Priority is youngest first: EX > MEM > WB. Duplicate dest in several stages always takes the youngest.

Gating:
- Operand 2 is evaluated only when id_uses_rs2=1; otherwise forward_c[3:2] = 2'b00.
- id_valid=0 or id_is_branch=0: forward_c = 4'b0000 and stall = 0. ALU load-use hazards belong to the main hazard unit.
- stall = need_stall on either operand. While stall=1, forward_c is still driven but is don't-care to consumers.

Stall timing:
- Load in EX: 2 stall cycles. The load moves EX→MEM, then MEM→WB, then WB forwards with code 11.
- Load in MEM: 1 stall cycle.
- Both operands stalling on different loads: stall lasts until the later one reaches WB.

stall_cycles:
- Increments on each clk edge where stall=1.
- Saturates at all-ones (no wrap). Cleared only by rst.

Test Plan:
- Reset: rst=1 with arbitrary inputs → forward_c=0000, stall=0, stall_cycles=0. Deassert → still 0 with an empty pipeline.
- ALU producer: ADD r3 (no load) issued; next cycle BEQ r3,r5 in ID with uses_rs2=1 → forward_c=0001, stall=0. Same branch one cycle later → 0010. Two cycles later → 0011. Three cycles later → 0000.
- Load-use: LD r4 issued; next cycle BNE r1,r4 → stall=1 for exactly 2 cycles, then forward_c=1100, stall=0. stall_cycles=2.
- Youngest priority: ADD r2 then SUB r2 back-to-back; branch reads r2 in rs1 → forward_c[1:0]=01 (SUB in EX), not 10.
- Flush/gating: flush=1 with a reg-writing r6 instruction in ID; next cycle branch on r6 → 0000. Non-branch instruction in ID with an EX hit → forward_c=0000, stall=0. id_uses_rs2=0 with an EX hit on rs2 → [3:2]=00.
- Reset mid-stall: LD r7 then branch on r7, assert rst during the first stall cycle → stall drops immediately. After release, the branch on r7 gives forward_c=0000, stall=0.
